imem_fetch_ctrl: RTL

Instruction-fetch controller between the PC register and a multi-cycle instruction memory. It samples the PC, performs a req/ack read, and presents the fetched instruction and its PC to the IF/ID stage. It drives the PC's hold input: high freezes the PC, low lets it load its next value. It also absorbs downstream stalls and branch flushes, including a flush that arrives while a read is still in flight.

---
 rtl/imem_fetch_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction-fetch controller that sits between the PC register and a
// multi-cycle instruction memory. It samples the PC and reads the instruction
// with a req/ack handshake. The fetched instruction and its PC are then
// presented to the IF/ID stage. The controller drives the PC hold input, so
// the PC advances exactly once per delivered instruction and exactly once per
// flush cycle. Downstream stalls are absorbed here, and so are branch flushes,
// including a flush that arrives while a read is still outstanding.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | sample pc_i and issue a request (unless a flush is redirecting)
// S_REQ  | request outstanding, waiting for mem_ack_i
// S_DONE | instruction valid, waiting for IF/ID to accept it
// S_DROP | flushed while in flight; wait out the ack and discard the data
//
// Ports
//   clk_i, rst_i        clock (rising edge) and synchronous active-high reset
//   pc_i                current PC value
//   hold_o              1 = PC holds, 0 = PC loads its next value
//   stall_i             IF/ID cannot accept an instruction this cycle
//   flush_i             branch/jump taken, PC loads redirect target this cycle
//   mem_req_o           read request (level), mem_addr_o stable while high
//   mem_ack_i           one-cycle data-valid pulse, mem_data_i sampled with it
//   inst_o, inst_pc_o   fetched instruction and its address
//   inst_valid_o        inst_o / inst_pc_o valid
//   fetch_cnt_o         number of instructions handed to IF/ID (wraps)
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              hold_o,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic [31:0]       fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_inst;
    logic [ADDR_W-1:0]   r_inst_pc;
    logic                r_inst_valid;
    logic [31:0]         r_fetch_cnt;

    state_t              w_state_nxt;
    logic                w_mem_req_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_inst_nxt;
    logic [ADDR_W-1:0]   w_inst_pc_nxt;
    logic                w_inst_valid_nxt;
    logic [31:0]         w_fetch_cnt_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_fetch_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_fetch_cnt  <= w_fetch_cnt_nxt;
        end
    end

    // mem_ack_i is only looked at in S_REQ / S_DROP, the only states in which
    // a request is outstanding, so a stray ack elsewhere has no effect.
    always_comb begin
        w_state_nxt      = r_state;
        w_mem_req_nxt    = r_mem_req;
        w_mem_addr_nxt   = r_mem_addr;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_inst_valid_nxt = r_inst_valid;
        w_fetch_cnt_nxt  = r_fetch_cnt;
        unique case (r_state)
            S_IDLE: begin
                // During a flush the PC is loading the redirect target, so
                // sampling pc_i now would fetch the stale address.
                if (!flush_i) begin
                    w_mem_addr_nxt = pc_i;
                    w_mem_req_nxt  = 1'b1;
                    w_state_nxt    = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack_i) begin
                    w_mem_req_nxt = 1'b0;
                    if (flush_i) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_inst_nxt       = mem_data_i;
                        w_inst_pc_nxt    = r_mem_addr;
                        w_inst_valid_nxt = 1'b1;
                        w_state_nxt      = S_DONE;
                    end
                end else if (flush_i) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DONE: begin
                if (flush_i) begin
                    w_inst_valid_nxt = 1'b0;
                    w_state_nxt      = S_IDLE;
                end else if (!stall_i) begin
                    w_inst_valid_nxt = 1'b0;
                    w_fetch_cnt_nxt  = r_fetch_cnt + 32'd1;
                    w_state_nxt      = S_IDLE;
                end
            end
            S_DROP: begin
                // Any further flush here only moves the PC; the outstanding
                // read still has to be drained before a new one is issued.
                if (mem_ack_i) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The PC advances on a handoff or a flush and is frozen otherwise.
    assign hold_o = rst_i | ~(flush_i | ((r_state == S_DONE) & ~stall_i));

    assign mem_req_o    = r_mem_req;
    assign mem_addr_o   = r_mem_addr;
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;
    assign inst_valid_o = r_inst_valid;
    assign fetch_cnt_o  = r_fetch_cnt;

endmodule
